sram_req_ctrl: RTL and testbench

//  Request front-end sitting directly upstream of sram_wrapper (1RW macro + wdata/rdata regs).

---
 rtl/sram_req_ctrl.sv | 145 ++++++++++++++
 tb/tb_sram_req_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - request front-end for the 1RW sram_wrapper: zero-fill, read latency tracking, credit-gated response FIFO
module sram_req_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 3,
  parameter int RSP_DEPTH = 4,
  parameter int INIT_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wmode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic              RW0_en,
  output logic              RW0_wmode,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int WORDS = 2**ADDR_W;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(RSP_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_issue;
  logic              run;

  logic              s1_valid_q, s1_wmode_q;
  logic [ADDR_W-1:0] s1_addr_q;

  logic [RD_LAT-1:0] rd_pipe_q;
  logic [CNT_W-1:0]  outstanding_q;
  logic              accept, rd_accept, push, pop;

  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // Zero-fill walks every address once, then hands over to RUN for good.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_issue = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_issue = 1'b1;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == ADDR_W'(WORDS - 1)) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign init_done = run;

  // A pop this cycle frees a credit, so a full FIFO can still accept in lockstep.
  assign pop       = rsp_valid & rsp_ready;
  assign req_ready = run & ((outstanding_q < CNT_W'(RSP_DEPTH)) | pop);
  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_wmode;

  // Wrapper registers wdata one cycle, so data goes out now and addr/en one cycle later.
  assign RW0_wdata = run ? req_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_wmode_q <= 1'b0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= init_issue | accept;
      if (init_issue) begin
        s1_addr_q  <= init_cnt_q;
        s1_wmode_q <= 1'b1;
      end else if (accept) begin
        s1_addr_q  <= req_addr;
        s1_wmode_q <= req_wmode;
      end else begin
        s1_wmode_q <= 1'b0;
      end
    end
  end

  assign RW0_en    = s1_valid_q;
  assign RW0_wmode = s1_wmode_q;
  assign RW0_addr  = s1_addr_q;

  // Top bit of the pipe marks the cycle RW0_rdata carries an accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe_q     <= '0;
      outstanding_q <= '0;
    end else begin
      rd_pipe_q     <= {rd_pipe_q[RD_LAT-2:0], rd_accept};
      outstanding_q <= outstanding_q + CNT_W'(rd_accept) - CNT_W'(pop);
    end
  end

  assign push = rd_pipe_q[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= RW0_rdata;
  end

  assign rsp_valid = (count_q != '0);
  assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr_q] : '0;

  assert property (@(posedge clk) disable iff (rst) !(push && count_q == CNT_W'(RSP_DEPTH)));
  assert property (@(posedge clk) disable iff (rst) !(pop && count_q == '0));
  assert property (@(posedge clk) disable iff (rst) outstanding_q <= CNT_W'(RSP_DEPTH));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - scoreboard bench for sram_req_ctrl with a behavioural sram_wrapper
module tb_sram_req_ctrl;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int RD_LAT    = 3;
  localparam int RSP_DEPTH = 4;
  localparam int WORDS     = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0, req_wmode = 1'b0, rsp_ready = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready, rsp_valid, init_done, RW0_en, RW0_wmode;
  logic [DATA_W-1:0] rsp_rdata, RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata = '0;
  logic [ADDR_W-1:0] RW0_addr;

  logic              req_valid0 = 1'b0, req_wmode0 = 1'b0;
  logic [ADDR_W-1:0] req_addr0 = '0;
  logic [DATA_W-1:0] req_wdata0 = '0;
  logic              req_ready0, rsp_valid0, init_done0, RW0_en0, RW0_wmode0;
  logic [DATA_W-1:0] rsp_rdata0, RW0_wdata0;
  logic [ADDR_W-1:0] RW0_addr0;
  logic [DATA_W-1:0] RW0_rdata0 = '0;

  sram_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
                  .RSP_DEPTH(RSP_DEPTH), .INIT_EN(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wmode(req_wmode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .RW0_addr(RW0_addr), .RW0_wdata(RW0_wdata),
    .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_rdata(RW0_rdata));

  sram_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
                  .RSP_DEPTH(RSP_DEPTH), .INIT_EN(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_wmode(req_wmode0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(1'b0), .rsp_rdata(rsp_rdata0),
    .init_done(init_done0), .RW0_addr(RW0_addr0), .RW0_wdata(RW0_wdata0),
    .RW0_en(RW0_en0), .RW0_wmode(RW0_wmode0), .RW0_rdata(RW0_rdata0));

  always #5 clk = ~clk;

  // Behavioural sram_wrapper: wdata register, macro output register, rdata register.
  logic [DATA_W-1:0] sram [WORDS];
  logic [DATA_W-1:0] wr_q = '0, dout = '0;
  logic              seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < WORDS; i++) sram[i] <= DATA_W'($urandom_range(1, 255));
      seeded <= 1'b1;
    end else if (RW0_en) begin
      if (RW0_wmode) sram[RW0_addr] <= wr_q;
      else           dout <= sram[RW0_addr];
    end
    wr_q      <= RW0_wdata;
    RW0_rdata <= dout;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: memory contents as seen by requests, and accepted reads awaiting pop.
  typedef struct { logic [DATA_W-1:0] data; int due; } exp_t;
  exp_t              exp_q [$];
  logic [DATA_W-1:0] model_mem [WORDS];
  int  cyc = 0;
  bit  sb_en = 0, chk_ready = 0;
  int  n_acc = 0, n_pop = 0, n_en0 = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (RW0_en0) n_en0++;
  end

  initial begin : monitor
    bit exp_valid, exp_pop;
    forever begin
      @(negedge clk);
      if (sb_en) begin
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        chk("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid) chk("rsp_rdata", rsp_rdata, exp_q[0].data);
        exp_pop = exp_valid && rsp_ready;
        if (chk_ready) chk("req_ready", req_ready, (exp_q.size() < RSP_DEPTH) || exp_pop);
        if (exp_pop) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
        if (req_valid && req_ready) begin
          n_acc++;
          if (req_wmode) model_mem[req_addr] = req_wdata;
          else exp_q.push_back('{data: model_mem[req_addr], due: cyc + RD_LAT + 1});
        end
      end
    end
  end

  task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic rr);
    @(posedge clk);
    #1;
    req_valid = v; req_wmode = w; req_addr = a; req_wdata = d; rsp_ready = rr;
  endtask

  task automatic do_reset();
    int nw, bad_seq, bad_flags;
    logic [ADDR_W-1:0] na;
    @(posedge clk);
    #1;
    rst = 1'b1; req_valid = 1'b0; req_wmode = 1'b0; rsp_ready = 1'b0; req_wdata = '0;
    sb_en = 0; chk_ready = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
    sb_en = 1;
    nw = 0; bad_seq = 0; bad_flags = 0; na = '0;
    @(negedge clk);
    chk("reset_outputs", {rsp_valid, req_ready, init_done, RW0_en, RW0_wmode,
                          RW0_addr, RW0_wdata, rsp_rdata}, 0);
    chk("noinit_flags", {req_ready0, init_done0, RW0_en0}, 3'b110);
    for (int k = 1; k <= WORDS + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= WORDS && (req_ready || init_done)) bad_flags++;
      if (k >= 2) begin
        if (!(RW0_en && RW0_wmode && RW0_addr == na && RW0_wdata == '0)) bad_seq++;
        na = na + 1'b1;
      end else if (RW0_en) bad_seq++;
      if (RW0_en) nw++;
    end
    chk("init_run_flags", {init_done, req_ready}, 2'b11);
    chk("init_writes", nw, WORDS);
    chk("init_seq", bad_seq, 0);
    chk("init_ready_low", bad_flags, 0);
    chk_ready = 1;
  endtask

  initial begin : stim
    int a0, p0, bad;
    repeat (3) @(posedge clk);
    do_reset();

    // INIT_EN=0 instance: idle until a request, then one write pulse
    chk("noinit_no_en", n_en0, 0);
    @(posedge clk);
    #1;
    req_valid0 = 1'b1; req_wmode0 = 1'b1; req_addr0 = 7'd5; req_wdata0 = 8'h77;
    @(negedge clk);
    chk("noinit_wdata", RW0_wdata0, 8'h77);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("noinit_en", {RW0_en0, RW0_wmode0, RW0_addr0}, {2'b11, 7'd5});

    // write then read-after-write on the next cycle
    drive(1, 1, 7'h10, 8'hA5, 0);
    drive(1, 0, 7'h10, 8'h00, 0);
    @(negedge clk);
    chk("raw_en_t1", {RW0_en, RW0_wmode, RW0_addr}, {2'b11, 7'h10});
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("raw_en_t2", {RW0_en, RW0_wmode, RW0_addr}, {2'b10, 7'h10});
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("raw_not_yet", rsp_valid, 0);
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("raw_rsp", {rsp_valid, rsp_rdata}, {1'b1, 8'hA5});
    drive(0, 0, 0, 0, 0);

    // credit gate: 6 reads offered with no pops
    for (int i = 0; i < 6; i++) drive(1, 1, 7'(8'h20 + i), 8'(8'h31 + i), 0);
    @(negedge clk);
    #1;
    a0 = n_acc;
    for (int i = 0; i < 6; i++) drive(1, 0, 7'(8'h20 + i), 0, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 7'h25, 0, 0);
      @(negedge clk);
      if (req_ready) bad++;
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("gate_accepts", n_acc - a0, 4);
    chk("gate_ready_low", bad, 0);
    p0 = n_pop;
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("gate_pops", n_pop - p0, 4);

    // full FIFO with pop and read every cycle
    for (int i = 0; i < 4; i++) drive(1, 0, 7'(8'h20 + i), 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    a0 = n_acc; p0 = n_pop; bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 7'($urandom_range(8'h20, 8'h25)), 0, 1);
      @(negedge clk);
      if (!(req_ready && rsp_valid)) bad++;
    end
    #1;
    chk("thru_accepts", n_acc - a0, 20);
    chk("thru_pops", n_pop - p0, 20);
    chk("thru_stall", bad, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1);

    // reset with reads in flight
    for (int i = 0; i < 3; i++) drive(1, 0, 7'(8'h20 + i), 0, 0);
    do_reset();

    // randomized traffic over a small address window to force collisions
    for (int i = 0; i < 800; i++)
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0),
            7'($urandom_range(0, 15)), 8'($urandom), logic'($urandom_range(0, 9) < 7));
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
